// File: rtl/flit_activity_monitor.sv
// ----------------------------------------------------------------------------
// flit_activity_monitor
// Measures switching activity of a flit stream. For every accepted flit it
// adds the Hamming distance to the previous flit (toggles) and the flit's
// popcount (ones) into saturating accumulators. After PAYLOAD flits it holds a
// packet report until the downstream side takes it.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   flit_valid/    : upstream flit handshake; flit_data is W bits
//   flit_data/
//   flit_ready
//   rpt_valid/     : packet report handshake
//   rpt_ready
//   rpt_toggles    : toggle accumulator (running value, valid with rpt_valid)
//   rpt_ones       : ones accumulator   (running value, valid with rpt_valid)
//   rpt_sat        : either accumulator saturated during this packet
//   pkt_count      : reports handed over since reset (wraps)
//   drop_count     : cycles with flit_valid=1 while not ready (saturates)
// ----------------------------------------------------------------------------
module flit_activity_monitor #(
   parameter int unsigned W       = 34,
   parameter int unsigned PAYLOAD = 20,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flit_valid,
   input  logic [W-1:0]     flit_data,
   output logic             flit_ready,
   output logic             rpt_valid,
   input  logic             rpt_ready,
   output logic [CNT_W-1:0] rpt_toggles,
   output logic [CNT_W-1:0] rpt_ones,
   output logic             rpt_sat,
   output logic [CNT_W-1:0] pkt_count,
   output logic [CNT_W-1:0] drop_count
);

   localparam int unsigned PC_W  = $clog2(W + 1);
   localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
   localparam int unsigned FC_W  = $clog2(PAYLOAD + 1);
   localparam logic [SUM_W-1:0] SAT_MAX   = SUM_W'({CNT_W{1'b1}});
   localparam logic [FC_W-1:0]  LAST_FLIT = FC_W'(PAYLOAD - 1);

   typedef enum logic {
      ST_RECV   = 1'b0,
      ST_REPORT = 1'b1
   } state_t;

   state_t           r_state;
   logic             r_flit_ready;
   logic             r_rpt_valid;
   logic [CNT_W-1:0] r_tog;
   logic [CNT_W-1:0] r_ones;
   logic             r_sat;
   logic [CNT_W-1:0] r_pkt;
   logic [CNT_W-1:0] r_drop;
   logic [W-1:0]     r_prev;
   logic [FC_W-1:0]  r_flit_cnt;

   logic [PC_W-1:0]  w_tog_pc;
   logic [PC_W-1:0]  w_ones_pc;
   logic [SUM_W-1:0] w_tog_sum;
   logic [SUM_W-1:0] w_ones_sum;
   logic             w_tog_ovf;
   logic             w_ones_ovf;
   logic [CNT_W-1:0] w_tog_next;
   logic [CNT_W-1:0] w_ones_next;
   logic             w_drop;

   // Population count of a W-bit vector
   function automatic logic [PC_W-1:0] popcnt(input logic [W-1:0] v);
      logic [PC_W-1:0] c;
      c = '0;
      for (int i = 0; i < W; i++) begin
         c = c + PC_W'(v[i]);
      end
      return c;
   endfunction

   // Saturating accumulator updates for the flit currently on the bus
   assign w_tog_pc    = popcnt(flit_data ^ r_prev);
   assign w_ones_pc   = popcnt(flit_data);
   assign w_tog_sum   = SUM_W'(r_tog) + SUM_W'(w_tog_pc);
   assign w_ones_sum  = SUM_W'(r_ones) + SUM_W'(w_ones_pc);
   assign w_tog_ovf   = (w_tog_sum > SAT_MAX);
   assign w_ones_ovf  = (w_ones_sum > SAT_MAX);
   assign w_tog_next  = w_tog_ovf  ? {CNT_W{1'b1}} : w_tog_sum[CNT_W-1:0];
   assign w_ones_next = w_ones_ovf ? {CNT_W{1'b1}} : w_ones_sum[CNT_W-1:0];
   assign w_drop      = flit_valid & ~r_flit_ready;

   // Receive/report FSM with accumulators and statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_RECV;
         r_flit_ready <= 1'b1;
         r_rpt_valid  <= 1'b0;
         r_tog        <= '0;
         r_ones       <= '0;
         r_sat        <= 1'b0;
         r_pkt        <= '0;
         r_drop       <= '0;
         r_prev       <= '0;
         r_flit_cnt   <= '0;
      end else begin
         if (w_drop && (r_drop != {CNT_W{1'b1}})) begin
            r_drop <= r_drop + CNT_W'(1);
         end
         case (r_state)
            ST_RECV: begin
               if (flit_valid) begin
                  r_tog      <= w_tog_next;
                  r_ones     <= w_ones_next;
                  r_sat      <= r_sat | w_tog_ovf | w_ones_ovf;
                  r_prev     <= flit_data;
                  r_flit_cnt <= r_flit_cnt + FC_W'(1);
                  if (r_flit_cnt == LAST_FLIT) begin
                     r_state      <= ST_REPORT;
                     r_flit_ready <= 1'b0;
                     r_rpt_valid  <= 1'b1;
                  end
               end
            end
            ST_REPORT: begin
               // prev flit survives the handshake; only per-packet state clears
               if (rpt_ready) begin
                  r_state      <= ST_RECV;
                  r_flit_ready <= 1'b1;
                  r_rpt_valid  <= 1'b0;
                  r_tog        <= '0;
                  r_ones       <= '0;
                  r_sat        <= 1'b0;
                  r_flit_cnt   <= '0;
                  r_pkt        <= r_pkt + CNT_W'(1);
               end
            end
            default: begin
               r_state      <= ST_RECV;
               r_flit_ready <= 1'b1;
               r_rpt_valid  <= 1'b0;
            end
         endcase
      end
   end

   assign flit_ready  = r_flit_ready;
   assign rpt_valid   = r_rpt_valid;
   assign rpt_toggles = r_tog;
   assign rpt_ones    = r_ones;
   assign rpt_sat     = r_sat;
   assign pkt_count   = r_pkt;
   assign drop_count  = r_drop;

endmodule
